cdc_toggle_rx: RTL and testbench

- Destination-side end of the toggle-based pulse clock-domain-crossing scheme.
- Takes a level toggle from a foreign (asynchronous) domain and synchronizes it into clk_in.
- Converts each toggle edge into exactly one single-cycle strobe, with downstream backpressure and a pending-event counter.
- Returns an acknowledge toggle so the source-side block can detect delivery and pace its next event.

---
 rtl/cdc_toggle_rx.sv | 80 ++++++++
 tb/tb_cdc_toggle_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_toggle_rx.sv
// Destination end of a toggle-based pulse CDC: synchronizes a foreign toggle,
// turns each edge into one strobe under backpressure and returns an ack toggle.
module cdc_toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 toggle_in,
  input  logic                 ready_in,
  output logic                 strobe_out,
  output logic                 ack_toggle_out,
  output logic [CNT_WIDTH-1:0] pending_out,
  output logic                 overflow_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_strobe;
  logic                   r_ack;
  logic                   r_overflow;
  logic [CNT_WIDTH-1:0]   r_pending;

  logic                   w_event;
  logic                   w_issue;
  logic                   w_overflowSet;
  logic [CNT_WIDTH-1:0]   w_pendingNext;

  // Plain flop chain: nothing but the reset mux may sit between stages.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], toggle_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_event = r_sync[SYNC_STAGES-1] ^ r_prev;
  assign w_issue = ready_in && (r_pending != '0);

  // A simultaneous event and issue cancel out, so saturation only matters
  // when an event arrives with nothing leaving.
  always_comb begin
    w_pendingNext = r_pending;
    w_overflowSet = 1'b0;
    if (w_event && !w_issue) begin
      if (r_pending == CNT_MAX) begin
        w_overflowSet = 1'b1;
      end else begin
        w_pendingNext = r_pending + 1'b1;
      end
    end else if (!w_event && w_issue) begin
      w_pendingNext = r_pending - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_strobe   <= 1'b0;
      r_ack      <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_strobe   <= w_issue;
      r_ack      <= r_sync[SYNC_STAGES-1];
      r_pending  <= w_pendingNext;
      r_overflow <= r_overflow | w_overflowSet;
    end
  end

  assign strobe_out     = r_strobe;
  assign ack_toggle_out = r_ack;
  assign pending_out    = r_pending;
  assign overflow_out   = r_overflow;

endmodule

// File: tb/tb_cdc_toggle_rx.sv
// Directed self-checking bench for cdc_toggle_rx; a 4-bit and a 2-bit counter
// instance share the same stimulus so saturation can be seen alongside normal counting.
module tb_cdc_toggle_rx;

  logic clk_in = 1'b0;
  logic srcClk = 1'b0;
  logic rst_in = 1'b1;
  logic ready_in = 1'b0;
  logic tbToggle = 1'b0;
  logic srcToggle = 1'b0;
  logic srcMode = 1'b0;
  logic toggle_in;

  logic       strobe4, ack4, overflow4;
  logic [3:0] pending4;
  logic       strobe2, ack2, overflow2;
  logic [1:0] pending2;

  int vectors = 0;
  int miscompares = 0;
  int strobeCount4 = 0;
  int strobeCount2 = 0;

  assign toggle_in = srcMode ? srcToggle : tbToggle;

  always #10 clk_in = ~clk_in;
  always #25 srcClk = ~srcClk;

  cdc_toggle_rx #(.SYNC_STAGES(2), .CNT_WIDTH(4)) dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .toggle_in(toggle_in), .ready_in(ready_in),
    .strobe_out(strobe4), .ack_toggle_out(ack4), .pending_out(pending4),
    .overflow_out(overflow4)
  );

  cdc_toggle_rx #(.SYNC_STAGES(2), .CNT_WIDTH(2)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .toggle_in(toggle_in), .ready_in(ready_in),
    .strobe_out(strobe2), .ack_toggle_out(ack2), .pending_out(pending2),
    .overflow_out(overflow2)
  );

  // Each edge sees the strobe value of the cycle just ending, so every high
  // cycle is counted once.
  always @(posedge clk_in) begin
    if (strobe4) strobeCount4 <= strobeCount4 + 1;
    if (strobe2) strobeCount2 <= strobeCount2 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic tog, input logic rdy,
                               input int cycles);
    rst_in   = rst;
    tbToggle = tog;
    ready_in = rdy;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    rst_in = 1'b0;
  endtask

  int base4, base2, timeouts, waitCnt;
  logic srcDone;

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    checkOutput("rst_strobe", strobe4, 0);
    checkOutput("rst_ack", ack4, 0);
    checkOutput("rst_pending", pending4, 0);
    checkOutput("rst_overflow", overflow4, 0);

    // Test 1: single event latency with ready high
    rst_in = 1'b0;
    tick(1);
    base4 = strobeCount4;
    tbToggle = 1'b1;
    tick(1);
    tick(1);
    checkOutput("t1_e2_pending", pending4, 0);
    checkOutput("t1_e2_ack", ack4, 0);
    tick(1);
    checkOutput("t1_e3_ack", ack4, 1);
    checkOutput("t1_e3_pending", pending4, 1);
    checkOutput("t1_e3_strobe", strobe4, 0);
    tick(1);
    checkOutput("t1_e4_strobe", strobe4, 1);
    checkOutput("t1_e4_pending", pending4, 0);
    tick(1);
    checkOutput("t1_e5_strobe", strobe4, 0);
    tick(5);
    checkOutput("t1_strobes", strobeCount4 - base4, 1);

    // Test 2: backpressure accumulates, then back-to-back drain
    resetDut();
    base4 = strobeCount4;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, ~tbToggle, 1'b0, 4);
    end
    tick(3);
    checkOutput("t2_pending", pending4, 3);
    checkOutput("t2_pending_cnt2", pending2, 3);
    checkOutput("t2_overflow_cnt2", overflow2, 0);
    checkOutput("t2_no_strobe", strobeCount4 - base4, 0);
    checkOutput("t2_ack", ack4, tbToggle);
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("t2_drain_strobe", strobe4, 1);
      checkOutput("t2_drain_pending", pending4, 2 - i);
    end
    tick(1);
    checkOutput("t2_drain_end", strobe4, 0);
    checkOutput("t2_strobes", strobeCount4 - base4, 3);

    // Test 3: saturation of the 2-bit counter
    resetDut();
    base4 = strobeCount4;
    base2 = strobeCount2;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, ~tbToggle, 1'b0, 4);
      checkOutput("t3_pending_cnt2", pending2, (i > 3) ? 3 : i);
      checkOutput("t3_overflow_cnt2", overflow2, (i >= 4) ? 1 : 0);
      checkOutput("t3_pending_cnt4", pending4, i);
    end
    checkOutput("t3_overflow_cnt4", overflow4, 0);
    ready_in = 1'b1;
    tick(10);
    checkOutput("t3_strobes_cnt2", strobeCount2 - base2, 3);
    checkOutput("t3_strobes_cnt4", strobeCount4 - base4, 5);
    checkOutput("t3_overflow_sticky", overflow2, 1);
    checkOutput("t3_pending_end", pending2, 0);
    resetDut();
    checkOutput("t3_overflow_cleared", overflow2, 0);

    // Test 4: new event lands on the issuing cycle
    resetDut();
    applyStimulus(1'b0, ~tbToggle, 1'b0, 4);
    checkOutput("t4_pending_pre", pending4, 1);
    base4 = strobeCount4;
    tbToggle = ~tbToggle;
    tick(2);
    ready_in = 1'b1;
    tick(1);
    checkOutput("t4_pending_hold", pending4, 1);
    checkOutput("t4_strobe1", strobe4, 1);
    tick(1);
    checkOutput("t4_strobe2", strobe4, 1);
    checkOutput("t4_pending_end", pending4, 0);
    tick(1);
    checkOutput("t4_strobe_end", strobe4, 0);
    checkOutput("t4_strobes", strobeCount4 - base4, 2);

    // Test 5: reset mid-backlog wipes everything
    resetDut();
    applyStimulus(1'b0, ~tbToggle, 1'b0, 4);
    applyStimulus(1'b0, ~tbToggle, 1'b0, 4);
    checkOutput("t5_pending_pre", pending4, 2);
    applyStimulus(1'b1, tbToggle, 1'b0, 1);
    checkOutput("t5_pending", pending4, 0);
    checkOutput("t5_strobe", strobe4, 0);
    checkOutput("t5_ack", ack4, 0);
    checkOutput("t5_overflow", overflow4, 0);
    base4 = strobeCount4;
    applyStimulus(1'b0, tbToggle, 1'b1, 6);
    checkOutput("t5_no_strobe", strobeCount4 - base4, 0);
    checkOutput("t5_pending_after", pending4, 0);

    // Test 6: handshaked source on its own 50 ns clock, random ready
    resetDut();
    base4 = strobeCount4;
    srcToggle = 1'b0;
    srcMode = 1'b1;
    srcDone = 1'b0;
    timeouts = 0;
    fork
      begin
        for (int e = 0; e < 20; e++) begin
          @(posedge srcClk);
          srcToggle = ~srcToggle;
          waitCnt = 0;
          do begin
            @(posedge srcClk);
            waitCnt++;
          end while (ack4 !== srcToggle && waitCnt < 20);
          if (ack4 !== srcToggle) timeouts++;
        end
        srcDone = 1'b1;
      end
      begin
        while (!srcDone) begin
          ready_in = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    ready_in = 1'b1;
    tick(20);
    checkOutput("t6_timeouts", timeouts, 0);
    checkOutput("t6_strobes", strobeCount4 - base4, 20);
    checkOutput("t6_overflow", overflow4, 0);
    checkOutput("t6_ack", ack4, toggle_in);
    checkOutput("t6_pending", pending4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
